round_pack_arbiter: RTL and testbench



---
 rtl/round_pack_arbiter.sv | 165 ++++++++++++++++
 tb/tb_round_pack_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/round_pack_arbiter.sv
// Two-requester round-robin front end for a round-and-pack core: one grant in flight,
// result held in a response register until the granted requester accepts it.
module round_pack_arbiter #(
    parameter int FLAG_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic              req_sign0,
    input  logic              req_sign1,
    input  logic [12:0]       req_exp0,
    input  logic [12:0]       req_exp1,
    input  logic [63:0]       req_sig0,
    input  logic [63:0]       req_sig1,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [63:0]       resp_data,
    output logic              resp_err,
    input  logic              flag_clr,
    output logic [FLAG_W-1:0] flags,
    output logic              core_start,
    input  logic              core_ready,
    output logic              core_zsign,
    output logic [12:0]       core_zexp,
    output logic [63:0]       core_zsig,
    output logic [FLAG_W-1:0] core_flag_i,
    input  logic [FLAG_W-1:0] core_flag_o,
    input  logic              core_flag_o_vld,
    input  logic [63:0]       core_return
);

    typedef enum logic [1:0] {IDLE, START, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [1:0]        req_ready_q, req_ready_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [63:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              clr_pend_q, clr_pend_d;
    logic              core_start_q, core_start_d;
    logic              zsign_q, zsign_d;
    logic [12:0]       zexp_q, zexp_d;
    logic [63:0]       zsig_q, zsig_d;
    logic [7:0]        wait_q, wait_d;
    logic              pick;

    // last_q doubles as the index of the in-flight grant while busy.
    assign pick = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        req_ready_d  = 2'b00;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        core_start_d = core_start_q;
        zsign_d      = zsign_q;
        zexp_d       = zexp_q;
        zsig_d       = zsig_q;
        wait_d       = wait_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    last_d       = pick;
                    req_ready_d  = pick ? 2'b10 : 2'b01;
                    zsign_d      = pick ? req_sign1 : req_sign0;
                    zexp_d       = pick ? req_exp1 : req_exp0;
                    zsig_d       = pick ? req_sig1 : req_sig0;
                    core_start_d = 1'b1;
                    wait_d       = 8'd0;
                    state_d      = START;
                end
            end
            START: begin
                if (core_ready) begin
                    resp_data_d  = core_return;
                    resp_err_d   = 1'b0;
                    core_start_d = 1'b0;
                    resp_valid_d = last_q ? 2'b10 : 2'b01;
                    state_d      = RESP;
                end else if (wait_q == 8'(TIMEOUT)) begin
                    resp_data_d  = 64'd0;
                    resp_err_d   = 1'b1;
                    core_start_d = 1'b0;
                    resp_valid_d = last_q ? 2'b10 : 2'b01;
                    state_d      = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready[last_q]) begin
                    resp_valid_d = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A core update always wins; a clear that collides with one, or arrives while
    // busy, is parked and applied on the first quiet IDLE cycle.
    always_comb begin
        flags_d    = flags_q;
        clr_pend_d = clr_pend_q;
        if (core_flag_o_vld) begin
            flags_d = core_flag_o;
            if (flag_clr) clr_pend_d = 1'b1;
        end else if (state_q == IDLE && (flag_clr || clr_pend_q)) begin
            flags_d    = '0;
            clr_pend_d = 1'b0;
        end else if (flag_clr) begin
            clr_pend_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            req_ready_q  <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_data_q  <= 64'd0;
            resp_err_q   <= 1'b0;
            flags_q      <= '0;
            clr_pend_q   <= 1'b0;
            core_start_q <= 1'b0;
            zsign_q      <= 1'b0;
            zexp_q       <= 13'd0;
            zsig_q       <= 64'd0;
            wait_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            flags_q      <= flags_d;
            clr_pend_q   <= clr_pend_d;
            core_start_q <= core_start_d;
            zsign_q      <= zsign_d;
            zexp_q       <= zexp_d;
            zsig_q       <= zsig_d;
            wait_q       <= wait_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign flags       = flags_q;
    assign core_flag_i = flags_q;
    assign core_start  = core_start_q;
    assign core_zsign  = zsign_q;
    assign core_zexp   = zexp_q;
    assign core_zsig   = zsig_q;

endmodule

// File: tb/tb_round_pack_arbiter.sv
// Directed bench for round_pack_arbiter: arbitration order, core handshake, timeout,
// sticky flags and mid-transaction reset.
module tb_round_pack_arbiter;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic        req_sign0, req_sign1, resp_err, flag_clr, core_start, core_ready;
    logic        core_zsign, core_flag_o_vld;
    logic [12:0] req_exp0, req_exp1, core_zexp;
    logic [63:0] req_sig0, req_sig1, resp_data, core_zsig, core_return;
    logic [31:0] flags, core_flag_i, core_flag_o;

    int checks = 0;
    int failures = 0;

    round_pack_arbiter #(.FLAG_W(32), .TIMEOUT(15)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sign0(req_sign0), .req_sign1(req_sign1),
        .req_exp0(req_exp0), .req_exp1(req_exp1),
        .req_sig0(req_sig0), .req_sig1(req_sig1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .flag_clr(flag_clr), .flags(flags),
        .core_start(core_start), .core_ready(core_ready),
        .core_zsign(core_zsign), .core_zexp(core_zexp), .core_zsig(core_zsig),
        .core_flag_i(core_flag_i), .core_flag_o(core_flag_o),
        .core_flag_o_vld(core_flag_o_vld), .core_return(core_return)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset;
        ap_rst_n = 1'b0;
        #3;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        req_valid = 2'b00; resp_ready = 2'b00;
        req_sign0 = 1'b0; req_sign1 = 1'b1;
        req_exp0 = 13'd0; req_exp1 = 13'd0;
        req_sig0 = 64'd0; req_sig1 = 64'd0;
        flag_clr = 1'b0; core_ready = 1'b0; core_flag_o_vld = 1'b0;
        core_flag_o = 32'd0; core_return = 64'd0;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_flags", flags, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_zexp", core_zexp, 0);
        check("rst_core_zsig", core_zsig, 0);

        // Single request, core answers in the third START cycle.
        #10;
        ap_rst_n = 1'b1;
        req_valid = 2'b01; req_exp0 = 13'd1023; req_sig0 = 64'h0010_0000_0000_0000;
        tick;
        check("t1_req_ready", req_ready, 2'b01);
        check("t1_start_c1", core_start, 1);
        check("t1_zexp", core_zexp, 13'd1023);
        check("t1_zsig", core_zsig, 64'h0010_0000_0000_0000);
        check("t1_zsign", core_zsign, 0);
        req_valid = 2'b00;
        tick;
        check("t1_req_ready_pulse", req_ready, 2'b00);
        check("t1_start_c2", core_start, 1);
        tick;
        check("t1_start_c3", core_start, 1);
        core_ready = 1'b1; core_return = 64'h3FF0_0000_0000_0000;
        tick;
        core_ready = 1'b0;
        check("t1_start_off", core_start, 0);
        check("t1_resp_valid", resp_valid, 2'b01);
        check("t1_resp_data", resp_data, 64'h3FF0_0000_0000_0000);
        check("t1_resp_err", resp_err, 0);
        resp_ready = 2'b10;
        tick;
        check("t1_wrong_ready_ignored", resp_valid, 2'b01);
        resp_ready = 2'b01;
        tick;
        check("t1_resp_done", resp_valid, 2'b00);
        resp_ready = 2'b00;

        // Both requesting continuously from a fresh reset: 0,1,0,1.
        do_reset;
        req_exp0 = 13'd100; req_exp1 = 13'd200;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] gbit;
            gbit = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick;
            check("rr_req_ready", req_ready, gbit);
            check("rr_zexp", core_zexp, (k % 2 == 0) ? 13'd100 : 13'd200);
            check("rr_zsign", core_zsign, (k % 2 == 0) ? 1'b0 : 1'b1);
            core_ready = 1'b1; core_return = 64'h1000 + 64'(k);
            tick;
            core_ready = 1'b0;
            check("rr_resp_valid", resp_valid, gbit);
            check("rr_resp_data", resp_data, 64'h1000 + 64'(k));
            resp_ready = gbit;
            tick;
            check("rr_resp_clear", resp_valid, 2'b00);
            resp_ready = 2'b00;
        end

        // Response held for 10 cycles with the other requester still pending.
        tick;
        check("hold_req_ready", req_ready, 2'b01);
        core_ready = 1'b1; core_return = 64'hDEAD_BEEF_0000_0001;
        tick;
        core_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("hold_resp_valid", resp_valid, 2'b01);
            check("hold_resp_data", resp_data, 64'hDEAD_BEEF_0000_0001);
            check("hold_no_grant", req_ready, 2'b00);
        end
        resp_ready = 2'b01; req_valid = 2'b00;
        tick;
        check("hold_release", resp_valid, 2'b00);
        resp_ready = 2'b00;

        // Core never answers: timeout after 16 START cycles.
        req_valid = 2'b10;
        tick;
        check("to_req_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        for (int i = 0; i < 15; i++) begin
            tick;
            check("to_start_held", core_start, 1);
            check("to_no_resp", resp_valid, 2'b00);
        end
        tick;
        check("to_resp_valid", resp_valid, 2'b10);
        check("to_resp_data", resp_data, 0);
        check("to_resp_err", resp_err, 1);
        check("to_start_off", core_start, 0);
        resp_ready = 2'b10;
        tick;
        check("to_resp_done", resp_valid, 2'b00);
        resp_ready = 2'b00;

        // Flag update and clear in the same START cycle; clear lands in IDLE.
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        core_flag_o = 32'h20; core_flag_o_vld = 1'b1; flag_clr = 1'b1;
        tick;
        core_flag_o_vld = 1'b0; flag_clr = 1'b0;
        check("fl_update", flags, 32'h20);
        check("fl_core_flag_i", core_flag_i, 32'h20);
        core_ready = 1'b1;
        tick;
        core_ready = 1'b0;
        check("fl_kept_in_resp", flags, 32'h20);
        resp_ready = 2'b01;
        tick;
        resp_ready = 2'b00;
        check("fl_first_idle", flags, 32'h20);
        tick;
        check("fl_cleared", flags, 0);
        core_flag_o = 32'h5; core_flag_o_vld = 1'b1;
        tick;
        core_flag_o_vld = 1'b0;
        check("fl_idle_update", flags, 32'h5);
        flag_clr = 1'b1;
        tick;
        flag_clr = 1'b0;
        check("fl_idle_clear", flags, 0);

        // Reset in START abandons the transaction.
        core_flag_o = 32'h3; core_flag_o_vld = 1'b1;
        req_valid = 2'b01; req_exp0 = 13'd7;
        tick;
        core_flag_o_vld = 1'b0; req_valid = 2'b00;
        check("mr_started", core_start, 1);
        check("mr_flags_set", flags, 32'h3);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("mr_core_start", core_start, 0);
        check("mr_zexp", core_zexp, 0);
        check("mr_flags", flags, 0);
        check("mr_resp_valid", resp_valid, 0);
        #3;
        ap_rst_n = 1'b1;
        core_ready = 1'b1; core_return = 64'h1234;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("mr_no_resp", resp_valid, 2'b00);
            check("mr_no_start", core_start, 0);
        end
        core_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
